// File: rtl/eth_bd_ram_arbiter_if.sv
// Bundle of the three requester ports, shared read data and the BD RAM pins
// seen by eth_bd_ram_arbiter.
interface eth_bd_ram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic          host_req;
  logic [BW-1:0] host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;

  logic          tx_req;
  logic [BW-1:0] tx_we;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_wdata;
  logic          tx_ack;

  logic          rx_req;
  logic [BW-1:0] rx_we;
  logic [AW-1:0] rx_addr;
  logic [DW-1:0] rx_wdata;
  logic          rx_ack;

  logic [DW-1:0] rdata;

  logic          ram_ce;
  logic [BW-1:0] ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack,
    input  tx_req, tx_we, tx_addr, tx_wdata,
    output tx_ack,
    input  rx_req, rx_we, rx_addr, rx_wdata,
    output rx_ack,
    output rdata,
    output ram_ce, ram_we, ram_oe, ram_addr, ram_di,
    input  ram_dout
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack,
    output tx_req, tx_we, tx_addr, tx_wdata,
    input  tx_ack,
    output rx_req, rx_we, rx_addr, rx_wdata,
    input  rx_ack,
    input  rdata,
    input  ram_ce, ram_we, ram_oe, ram_addr, ram_di,
    output ram_dout
  );
endinterface

// File: rtl/eth_bd_ram_arbiter.sv
// Three-port (rx > tx > host, with host starvation guard) arbiter in front of
// the single-port buffer-descriptor RAM.
module eth_bd_ram_arbiter #(
  parameter int AW            = 8,
  parameter int DW            = 32,
  parameter int HOST_MAX_WAIT = 4
) (
  input logic                clk,
  input logic                rst,
  eth_bd_ram_arbiter_if.slave bus
);
  localparam int BW  = DW / 8;
  localparam int WCW = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(HOST_MAX_WAIT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDATA  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_HOST = 2'd1;
  localparam logic [1:0] G_TX   = 2'd2;
  localparam logic [1:0] G_RX   = 2'd3;

  logic [1:0]     state;
  logic [1:0]     grant;
  logic [1:0]     pick;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_nxt;
  logic [BW-1:0]  we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  rdata_q;
  logic           busy;

  always_comb begin
    pick = G_NONE;
    if (bus.host_req && wait_cnt == WAIT_MAX) pick = G_HOST;
    else if (bus.rx_req)                      pick = G_RX;
    else if (bus.tx_req)                      pick = G_TX;
    else if (bus.host_req)                    pick = G_HOST;
  end

  // Starvation counter only advances on an IDLE arbitration the host loses.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!bus.host_req) begin
      wait_nxt = '0;
    end else if (state == IDLE) begin
      if (pick == G_HOST)            wait_nxt = '0;
      else if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= G_NONE;
      wait_cnt <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      case (state)
        IDLE: begin
          grant <= pick;
          if (pick != G_NONE) state <= ACCESS;
          case (pick)
            G_HOST: begin
              we_q    <= bus.host_we;
              addr_q  <= bus.host_addr;
              wdata_q <= bus.host_wdata;
            end
            G_TX: begin
              we_q    <= bus.tx_we;
              addr_q  <= bus.tx_addr;
              wdata_q <= bus.tx_wdata;
            end
            G_RX: begin
              we_q    <= bus.rx_we;
              addr_q  <= bus.rx_addr;
              wdata_q <= bus.rx_wdata;
            end
            default: ;
          endcase
        end
        ACCESS: state <= (we_q == '0) ? RDATA : DONE;
        RDATA: begin
          rdata_q <= bus.ram_dout;
          state   <= DONE;
        end
        default: begin
          state <= IDLE;
          grant <= G_NONE;
        end
      endcase
    end
  end

  // RAM strobes are gated by rst so a reset edge never commits a write.
  assign busy         = (state == ACCESS || state == RDATA) && !rst;
  assign bus.ram_ce   = busy;
  assign bus.ram_we   = (busy && state == ACCESS) ? we_q : '0;
  assign bus.ram_oe   = busy && state == RDATA;
  assign bus.ram_addr = busy ? addr_q : '0;
  assign bus.ram_di   = (busy && state == ACCESS) ? wdata_q : '0;

  assign bus.host_ack = !rst && state == DONE && grant == G_HOST;
  assign bus.tx_ack   = !rst && state == DONE && grant == G_TX;
  assign bus.rx_ack   = !rst && state == DONE && grant == G_RX;
  assign bus.rdata    = rdata_q;
endmodule
